os_xor_fold_acc: RTL and testbench

//   Downstream consumer of the 7-bit OS_XOR2 partial-product XOR network output.

---
 rtl/os_xor_fold_acc.sv | 86 ++++++++
 tb/tb_os_xor_fold_acc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/os_xor_fold_acc.sv
// XOR-folds up to BEATS y words (or fewer, on in_last) from the XOR network into one
// frame syndrome, presented with its parity and beat count on a registered valid/ready stage.
module os_xor_fold_acc #(
    parameter int DW    = 7,
    parameter int BEATS = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_parity,
    output logic [CW-1:0] out_beats,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;

    logic          in_fire;
    logic          out_fire;
    logic          closing;
    logic [DW-1:0] folded;

    // A result draining this cycle frees the output slot for a new close.
    assign in_ready = ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign busy     = (state == ACCUM);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        folded  = in_data;
        closing = 1'b0;
        if (state == ACCUM) begin
            folded = acc ^ in_data;
        end
        if (in_fire && (in_last || cnt == CW'(BEATS - 1))) begin
            closing = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_beats  <= '0;
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (closing) begin
                out_valid  <= 1'b1;
                out_data   <= folded;
                out_parity <= ^folded;
                out_beats  <= cnt + CW'(1);
                acc        <= '0;
                cnt        <= '0;
                state      <= IDLE;
            end else if (in_fire) begin
                acc   <= folded;
                cnt   <= cnt + CW'(1);
                state <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_os_xor_fold_acc.sv
// Self-checking bench for os_xor_fold_acc: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a frame-list reference model.
module tb_os_xor_fold_acc;

    localparam int DW    = 7;
    localparam int BEATS = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_parity;
    logic [CW-1:0] out_beats;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    os_xor_fold_acc #(.DW(DW), .BEATS(BEATS), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_parity(out_parity),
        .out_beats (out_beats),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: words of the open frame kept in a list; the result slot is a
    // plain valid flag plus the folded value, beat count and parity.
    logic [DW-1:0] frame_q[$];
    bit            m_valid  = 1'b0;
    logic [DW-1:0] m_data   = '0;
    bit            m_parity = 1'b0;
    int            m_beats  = 0;
    bit            m_fire   = 1'b0;
    bit            cmp_en   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            frame_q.delete();
            m_valid  = 1'b0;
            m_data   = '0;
            m_parity = 1'b0;
            m_beats  = 0;
            m_fire   = 1'b0;
        end else begin
            m_fire = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_fire) begin
                frame_q.push_back(in_data);
                if (in_last || frame_q.size() == BEATS) begin
                    logic [DW-1:0] x;
                    x = '0;
                    foreach (frame_q[i]) x = x ^ frame_q[i];
                    m_data   = x;
                    m_parity = ^x;
                    m_beats  = frame_q.size();
                    m_valid  = 1'b1;
                    frame_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_out_valid", out_valid, m_valid);
            check("m_out_data", out_data, m_data);
            check("m_out_parity", out_parity, m_parity);
            check("m_out_beats", out_beats, m_beats);
            check("m_in_ready", in_ready, !m_valid || out_ready);
            check("m_busy", busy, frame_q.size() != 0);
        end
    end

    task automatic send(input logic [DW-1:0] w, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = DW'($urandom);
    endtask

    logic [DW-1:0] stream_w[3] = '{7'h11, 7'h22, 7'h33};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 7'h5A;
        in_last   = 1'b1;
        out_ready = 1'b1;

        // 1: reset held two clocks with in_valid asserted
        repeat (2) begin
            @(posedge clk);
            #1;
            cmp_en = 1'b1;
            @(negedge clk);
            check("t1_out_valid", out_valid, 0);
            check("t1_busy", busy, 0);
            check("t1_in_ready", in_ready, 1);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_no_frame", out_valid, 0);
        @(posedge clk);
        #1;

        // 2: full frame of BEATS words
        send(7'h01, 0);
        send(7'h02, 0);
        send(7'h04, 0);
        send(7'h08, 0);
        @(negedge clk);
        check("t2_valid", out_valid, 1);
        check("t2_data", out_data, 7'h0F);
        check("t2_parity", out_parity, 0);
        check("t2_beats", out_beats, 4);
        check("t2_busy", busy, 0);
        @(posedge clk);
        #1;

        // 3: early close on the second beat
        send(7'h55, 0);
        send(7'h7F, 1);
        @(negedge clk);
        check("t3_data", out_data, 7'h2A);
        check("t3_parity", out_parity, 1);
        check("t3_beats", out_beats, 2);
        @(posedge clk);
        #1;

        // 4: backpressure holds the result and stalls the source
        out_ready = 1'b0;
        send(7'h40, 1);
        in_valid = 1'b1;
        in_data  = 7'h01;
        in_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4_in_ready", in_ready, 0);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_data", out_data, 7'h40);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_release", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(7'h02, 1);
        @(negedge clk);
        check("t4_next_data", out_data, 7'h03);
        check("t4_next_beats", out_beats, 2);
        @(posedge clk);
        #1;

        // 5: streaming single-beat frames, one result per clock
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = stream_w[i];
            @(negedge clk);
            check("t5_in_ready", in_ready, 1);
            if (i > 0) begin
                check("t5_data", out_data, stream_w[i-1]);
                check("t5_beats", out_beats, 1);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("t5_last_data", out_data, 7'h33);
        check("t5_last_valid", out_valid, 1);
        @(posedge clk);
        #1;

        // 6: reset mid-frame discards accumulated beats
        send(7'h03, 0);
        send(7'h05, 0);
        @(negedge clk);
        check("t6_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(7'h10, 1);
        @(negedge clk);
        check("t6_data", out_data, 7'h10);
        check("t6_beats", out_beats, 1);
        @(posedge clk);
        #1;

        // Randomized traffic; a stalled word is held until accepted.
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!(in_valid && !m_fire) || rst) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = DW'($urandom);
                in_last  = ($urandom_range(0, 4) == 0);
            end
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
